// File: rtl/room_pkg.sv
// rtl/room_pkg.sv - mode encodings, default constants and saturating arithmetic for the room plant
package room_pkg;

    typedef enum logic [1:0] {
        MODE_DRIFT = 2'd0,
        MODE_COOL  = 2'd1,
        MODE_HEAT  = 2'd2,
        MODE_FAULT = 2'd3
    } mode_t;

    localparam int unsigned DEF_TICK_DIV  = 16;
    localparam int unsigned DEF_DRIFT_DIV = 4;
    localparam int unsigned DEF_COOL_STEP = 2;
    localparam int unsigned DEF_HEAT_STEP = 2;
    localparam int unsigned DEF_INIT_TEMP = 22;
    localparam int unsigned DEF_T_MIN     = 0;
    localparam int unsigned DEF_T_MAX     = 60;

    // Differences are formed in 9 bits so a step below zero saturates instead of wrapping to 255.
    function automatic logic [7:0] sat_sub(input logic [7:0] t, input logic [8:0] step,
                                           input logic [7:0] lo);
        logic [8:0] t9;
        t9 = {1'b0, t};
        if (t9 < step + {1'b0, lo})
            return lo;
        return 8'(t9 - step);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] t, input logic [8:0] step,
                                           input logic [7:0] hi);
        logic [8:0] s;
        s = {1'b0, t} + step;
        if (s > {1'b0, hi})
            return hi;
        return s[7:0];
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
        if (v < lo)
            return lo;
        if (v > hi)
            return hi;
        return v;
    endfunction

    function automatic logic [7:0] step_toward(input logic [7:0] t, input logic [7:0] target);
        if (t < target)
            return t + 8'd1;
        if (t > target)
            return t - 8'd1;
        return t;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider giving a 1-cycle tick on the last count
module tick_divider #(
    parameter int unsigned DIV = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Tick is combinational so the consumer acts on the very edge where cnt==LAST.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/room_temp_model.sv
// rtl/room_temp_model.sv - closed-loop room thermal plant driven by cool/heat commands
module room_temp_model
    import room_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned DRIFT_DIV = DEF_DRIFT_DIV,
    parameter int unsigned COOL_STEP = DEF_COOL_STEP,
    parameter int unsigned HEAT_STEP = DEF_HEAT_STEP,
    parameter int unsigned INIT_TEMP = DEF_INIT_TEMP,
    parameter int unsigned T_MIN     = DEF_T_MIN,
    parameter int unsigned T_MAX     = DEF_T_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cool_i,
    input  logic       heat_i,
    input  logic [7:0] ambient_i,
    output logic [7:0] sensor_o,
    output logic       sample_o,
    output logic       fault_o
);

    localparam int unsigned DW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV) : 1;
    localparam logic [DW-1:0] DRIFT_LAST = DW'(DRIFT_DIV - 1);
    localparam logic [8:0] COOL9 = 9'(COOL_STEP);
    localparam logic [8:0] HEAT9 = 9'(HEAT_STEP);
    localparam logic [7:0] TMIN8 = 8'(T_MIN);
    localparam logic [7:0] TMAX8 = 8'(T_MAX);
    localparam logic [7:0] INIT8 = 8'(INIT_TEMP);

    mode_t          mode, mode_next;
    logic           tick;
    logic [DW-1:0]  drift_cnt, drift_next;
    logic [7:0]     temp_next;
    logic [7:0]     amb_c;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Mode follows the inputs every cycle regardless of the current mode.
    always_comb begin
        mode_next = MODE_DRIFT;
        case ({cool_i, heat_i})
            2'b11:   mode_next = MODE_FAULT;
            2'b10:   mode_next = MODE_COOL;
            2'b01:   mode_next = MODE_HEAT;
            default: mode_next = MODE_DRIFT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            mode <= MODE_DRIFT;
        else
            mode <= mode_next;
    end

    assign amb_c = clamp(ambient_i, TMIN8, TMAX8);

    always_comb begin
        temp_next  = sensor_o;
        drift_next = drift_cnt;
        if (mode != MODE_DRIFT)
            drift_next = '0;
        if (tick) begin
            case (mode)
                MODE_COOL: temp_next = sat_sub(sensor_o, COOL9, TMIN8);
                MODE_HEAT: temp_next = sat_add(sensor_o, HEAT9, TMAX8);
                MODE_DRIFT: begin
                    if (drift_cnt == DRIFT_LAST) begin
                        drift_next = '0;
                        temp_next  = step_toward(sensor_o, amb_c);
                    end else begin
                        drift_next = drift_cnt + DW'(1);
                    end
                end
                default: temp_next = sensor_o;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sensor_o  <= INIT8;
            sample_o  <= 1'b0;
            fault_o   <= 1'b0;
            drift_cnt <= '0;
        end else begin
            sensor_o  <= temp_next;
            sample_o  <= tick;
            fault_o   <= (mode == MODE_FAULT);
            drift_cnt <= drift_next;
        end
    end

endmodule
